// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM address and registers
// each returned byte into the IR, with stall, jump redirect and halt handling.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RESET_PC   = 0,
    parameter int WRAP_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  stall,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  halted,
    output logic [7:0]            fetch_count
);

    typedef enum logic {FETCH, HALTED} state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_LAST = '1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 8'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (jump_valid) begin
                        // Redirect flushes the byte fetched this cycle; a jump to the
                        // live instruction's own address is the halt idiom.
                        pc          <= jump_target;
                        instr_valid <= 1'b0;
                        if (instr_valid && (jump_target == instr_pc)) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr       <= imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        if (fetch_count != 8'hFF)
                            fetch_count <= fetch_count + 8'd1;
                        // Without wrap, the last address is still issued, then fetch stops.
                        if ((WRAP_EN == 0) && (pc == PC_LAST)) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    instr_valid <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Table-driven bench with an expectation queue for instruction_fetch; instance a
// wraps, instance b has wrap disabled.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       stall = 1'b0, jump_valid = 1'b0;
    logic [3:0] jump_target = 4'd0;

    logic [3:0] addr_a, addr_b, ipc_a, ipc_b;
    logic [7:0] ins_a, ins_b, cnt_a, cnt_b;
    logic       v_a, v_b, h_a, h_b;
    logic [7:0] rom [16];

    always #5 clk = ~clk;

    instruction_fetch #(.WRAP_EN(1)) dut_a (
        .clk(clk), .reset(rst_a), .imem_addr(addr_a), .imem_data(rom[addr_a]),
        .stall(stall), .jump_valid(jump_valid), .jump_target(jump_target),
        .instr(ins_a), .instr_pc(ipc_a), .instr_valid(v_a), .halted(h_a),
        .fetch_count(cnt_a));

    instruction_fetch #(.WRAP_EN(0)) dut_b (
        .clk(clk), .reset(rst_b), .imem_addr(addr_b), .imem_data(rom[addr_b]),
        .stall(stall), .jump_valid(jump_valid), .jump_target(jump_target),
        .instr(ins_b), .instr_pc(ipc_b), .instr_valid(v_b), .halted(h_b),
        .fetch_count(cnt_b));

    typedef struct {
        logic       rst, stl, jv;
        logic [3:0] jt;
        logic       v;
        logic [3:0] pc;
        logic [7:0] ins;
        logic       h;
        logic [7:0] cnt;
        logic [3:0] addr;
    } vec_t;

    typedef struct {
        bit         sel;
        bit         chk_ir;
        logic       v;
        logic [3:0] pc;
        logic [7:0] ins;
        logic       h;
        logic [7:0] cnt;
        logic [3:0] addr;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   stepno = 0;

    function automatic vec_t mk(logic rst, logic stl, logic jv, logic [3:0] jt, logic v,
                                logic [3:0] pc, logic [7:0] ins, logic h, logic [7:0] cnt,
                                logic [3:0] addr);
        vec_t t;
        t.rst = rst; t.stl = stl; t.jv = jv; t.jt = jt; t.v = v; t.pc = pc;
        t.ins = ins; t.h = h; t.cnt = cnt; t.addr = addr;
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step %0d %s: got %0h expected %0h", stepno, nm, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL step %0d scoreboard: got empty queue expected an entry", stepno);
            return;
        end
        e = sbq.pop_front();
        if (!e.sel) begin
            cmp("a.instr_valid", {7'd0, v_a}, {7'd0, e.v});
            cmp("a.halted", {7'd0, h_a}, {7'd0, e.h});
            cmp("a.fetch_count", cnt_a, e.cnt);
            cmp("a.imem_addr", {4'd0, addr_a}, {4'd0, e.addr});
            if (e.chk_ir) begin
                cmp("a.instr", ins_a, e.ins);
                cmp("a.instr_pc", {4'd0, ipc_a}, {4'd0, e.pc});
            end
        end else begin
            cmp("b.instr_valid", {7'd0, v_b}, {7'd0, e.v});
            cmp("b.halted", {7'd0, h_b}, {7'd0, e.h});
            cmp("b.fetch_count", cnt_b, e.cnt);
            cmp("b.imem_addr", {4'd0, addr_b}, {4'd0, e.addr});
            if (e.chk_ir) begin
                cmp("b.instr", ins_b, e.ins);
                cmp("b.instr_pc", {4'd0, ipc_b}, {4'd0, e.pc});
            end
        end
    endtask

    task automatic step(input bit sel, input vec_t t);
        exp_t e;
        @(negedge clk);
        if (sel) rst_b = t.rst; else rst_a = t.rst;
        stall = t.stl; jump_valid = t.jv; jump_target = t.jt;
        e.sel = sel; e.chk_ir = t.v || t.rst; e.v = t.v; e.pc = t.pc; e.ins = t.ins;
        e.h = t.h; e.cnt = t.cnt; e.addr = t.addr;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        stepno++;
        check_out();
    endtask

    initial begin
        rom = '{8'hAD, 8'hB6, 8'hC7, 8'h0A, 8'h32, 8'h4B, 8'h6B, 8'h7F,
                8'h8B, 8'h9C, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'h00};

        // rst stl jv jt | valid pc instr halted count addr
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'hAD, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8'hB6, 0, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 8'hC7, 0, 3, 3));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 0, 0, 1, 2, 8'hC7, 0, 3, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 8'h0A, 0, 4, 4));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 8'h00, 0, 4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8'hB6, 0, 5, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 8'hC7, 0, 6, 3));
        tbl.push_back(mk(0, 1, 1, 5, 0, 0, 8'h00, 0, 6, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 8'h4B, 0, 7, 6));
        tbl.push_back(mk(0, 0, 0, 0, 1, 6, 8'h6B, 0, 8, 7));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 8'h7F, 0, 9, 8));
        tbl.push_back(mk(0, 0, 1, 7, 0, 0, 8'h00, 1, 9, 7));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, i[0], i[1], 4'(i + 2), 0, 0, 8'h00, 1, 9, 7));
        tbl.push_back(mk(1, 1, 1, 9, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'hAD, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8'hB6, 0, 2, 2));

        foreach (tbl[i]) step(1'b0, tbl[i]);

        // Free run across several wraps into count saturation.
        step(1'b0, mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 300; i++)
            step(1'b0, mk(0, 0, 0, 0, 1, 4'(i % 16), rom[i % 16], 0,
                          8'((i + 1 > 255) ? 255 : i + 1), 4'((i + 1) % 16)));

        // Wrap disabled: last address issued, halt on the same edge, then frozen.
        step(1'b1, mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            step(1'b1, mk(0, 0, 0, 0, 1, 4'(i), rom[i], (i == 15), 8'(i + 1),
                          (i == 15) ? 4'd15 : 4'(i + 1)));
        for (int i = 0; i < 4; i++)
            step(1'b1, mk(0, i[0], i[1], 4'd3, 0, 0, 8'h00, 1, 16, 15));

        if (sbq.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
